// File: rtl/apb_master_ctrl.sv
// APB initiator for the AHB2APB bridge: takes single requests over a valid/ready
// channel, runs one APB SETUP/ACCESS transfer per request and returns a one-cycle
// response pulse carrying read data or an error flag.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        dec_sel;

  // Peripheral decode on the top six address bits; zero means unmapped.
  always_comb begin
    dec_sel = 3'b000;
    case (req_addr[31:26])
      6'h20:   dec_sel = 3'b001;
      6'h21:   dec_sel = 3'b010;
      6'h22:   dec_sel = 3'b100;
      default: dec_sel = 3'b000;
    endcase
  end

  // Next-state and next-output logic for the SETUP/ACCESS sequencer.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_sel != 3'b000) begin
            psel_d   = dec_sel;
            paddr_d  = req_addr;
            pwdata_d = req_wdata;
            pwrite_d = req_write;
            state_d  = SETUP;
          end else begin
            // Unmapped: answer with an error without touching the APB bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (Pready) begin
          psel_d      = 3'b000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) rsp_rdata_d = Prdata;
          state_d     = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          psel_d      = 3'b000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared immediately by the async reset.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q     <= IDLE;
      psel_q      <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign Pselx     = psel_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
